// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: E-stage MULT/MULTU/DIV/DIVU sequencer (restoring divider; multiplier is shift-add when MULDIV_ITER_MULT_EN, else registered '*').
// Divide/iterative multiply reach DONE WIDTH+1 cycles after start, single-cycle multiply after 1; busy stalls E, DONE holds hi/lo until advanceE/cancelE.
module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             startE,
    input  logic [1:0]       opE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             advanceE,
    input  logic             cancelE,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, rem_q, rem_d, raw_a_q, raw_a_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             qsign_q, qsign_d, rsign_q, rsign_d, dz_q, dz_d;
`ifdef MULDIV_ITER_MULT_EN
    logic             is_div_q, is_div_d;
    logic [WIDTH:0]   msum;
    logic [2*WIDTH-1:0] prod;
`else
    logic [2*WIDTH-1:0] prod1;
`endif
    logic             sa, sb;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   part, diff;
    logic [WIDTH-1:0] step_hi, step_lo, fin_hi, fin_lo;

    // Signs only matter for the signed ops (opE[0] == 0).
    assign sa    = srcaE[WIDTH-1] & ~opE[0];
    assign sb    = srcbE[WIDTH-1] & ~opE[0];
    assign mag_a = sa ? -srcaE : srcaE;
    assign mag_b = sb ? -srcbE : srcbE;
`ifndef MULDIV_ITER_MULT_EN
    assign prod1 = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`endif

    always_comb begin
        part    = {rem_q, a_q[WIDTH-1]};
        diff    = part - {1'b0, b_q};
        step_hi = diff[WIDTH] ? part[WIDTH-1:0] : diff[WIDTH-1:0];
        step_lo = {a_q[WIDTH-2:0], ~diff[WIDTH]};
        fin_hi  = rsign_q ? -step_hi : step_hi;
        fin_lo  = qsign_q ? -step_lo : step_lo;
        if (dz_q) begin
            fin_hi = raw_a_q;
            fin_lo = '1;
        end
`ifdef MULDIV_ITER_MULT_EN
        // Multiply reuses rem_q/a_q as the upper/lower halves of the accumulator.
        msum = {1'b0, rem_q} + (a_q[0] ? {1'b0, b_q} : '0);
        prod = '0;
        if (!is_div_q) begin
            step_hi = msum[WIDTH:1];
            step_lo = {msum[0], a_q[WIDTH-1:1]};
            prod    = {step_hi, step_lo};
            if (qsign_q) prod = -prod;
            fin_hi  = prod[2*WIDTH-1:WIDTH];
            fin_lo  = prod[WIDTH-1:0];
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        raw_a_d = raw_a_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        qsign_d = qsign_q;
        rsign_d = rsign_q;
        dz_d    = dz_q;
`ifdef MULDIV_ITER_MULT_EN
        is_div_d = is_div_q;
`endif
        busy    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (startE && !cancelE) begin
                    busy    = 1'b1;
                    a_d     = mag_a;
                    b_d     = mag_b;
                    rem_d   = '0;
                    cnt_d   = '0;
                    raw_a_d = srcaE;
                    qsign_d = sa ^ sb;
                    rsign_d = sa;
                    dz_d    = opE[1] && (srcbE == '0);
                    state_d = CALC;
`ifdef MULDIV_ITER_MULT_EN
                    is_div_d = opE[1];
                    if (!opE[1]) begin
                        a_d = mag_b;
                        b_d = mag_a;
                    end
`else
                    if (!opE[1]) begin
                        {hi_d, lo_d} = (sa ^ sb) ? -prod1 : prod1;
                        state_d      = DONE;
                    end
`endif
                end
            end
            CALC: begin
                busy = 1'b1;
                if (cancelE) begin
                    state_d = IDLE;
                end else begin
                    rem_d = step_hi;
                    a_d   = step_lo;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        hi_d    = fin_hi;
                        lo_d    = fin_lo;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // Stay put while E is stalled elsewhere; startE still high here is the same instruction.
                if (cancelE || advanceE) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            raw_a_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            dz_q    <= 1'b0;
`ifdef MULDIV_ITER_MULT_EN
            is_div_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            raw_a_q <= raw_a_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            qsign_q <= qsign_d;
            rsign_q <= rsign_d;
            dz_q    <= dz_d;
`ifdef MULDIV_ITER_MULT_EN
            is_div_q <= is_div_d;
`endif
        end
    end

    assign result_valid = (state_q == DONE);
    assign hi           = hi_q;
    assign lo           = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Testbench for muldiv_ctrl: random and directed MULT/MULTU/DIV/DIVU against an arithmetic reference model.
// Expected results queue at issue; a negedge monitor pops one per rising result_valid.
module tb_muldiv_ctrl;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          resetn;
    logic          startE;
    logic [1:0]    opE;
    logic [W-1:0]  srcaE, srcbE;
    logic          advanceE, cancelE;
    logic          busy, result_valid;
    logic [W-1:0]  hi, lo;

    int            checks = 0;
    int            errors = 0;
    logic [63:0]   exp_q[$];
    logic [W-1:0]  last_hi = '0;
    logic [W-1:0]  last_lo = '0;

    muldiv_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .resetn(resetn), .startE(startE), .opE(opE),
        .srcaE(srcaE), .srcbE(srcbE), .advanceE(advanceE), .cancelE(cancelE),
        .busy(busy), .result_valid(result_valid), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: {hi, lo} straight from integer arithmetic.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: res = sa * sb;
            2'b01: res = {32'b0, a} * {32'b0, b};
            default: begin
                if (b == 32'd0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else if (op == 2'b10) begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {r[31:0], q[31:0]};
                end else begin
                    res = {a % b, a / b};
                end
            end
        endcase
        return res;
    endfunction

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'($urandom_range(1, 20));
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
            default: return $urandom();
        endcase
    endfunction

    // Monitor: one scoreboard pop per DONE entry.
    initial begin
        logic        rv_prev;
        logic [63:0] e;
        rv_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (result_valid && !rv_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got hi=%h lo=%h with nothing outstanding", hi, lo);
                end else begin
                    e = exp_q.pop_front();
                    chk({hi, lo} === e, "result", {hi, lo}, e);
                end
            end
            rv_prev = result_valid;
        end
    end

    // Called and returns at posedge+1.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [63:0] e;
        int          n;
        int          exp_busy;
        e = model(op, a, b);
        exp_q.push_back(e);
`ifdef MULDIV_ITER_MULT_EN
        exp_busy = W + 1;
`else
        exp_busy = op[1] ? W + 1 : 1;
`endif
        startE = 1'b1; opE = op; srcaE = a; srcbE = b; advanceE = 1'b0; cancelE = 1'b0;
        n = 0;
        @(negedge clk);
        chk(result_valid === 1'b0, "rv_at_start", 64'(result_valid), 64'd0);
        while (busy && n < 100) begin
            n++;
            chk({hi, lo} === {last_hi, last_lo}, "hilo_stable_busy", {hi, lo}, {last_hi, last_lo});
            @(negedge clk);
        end
        chk(n == exp_busy, "busy_cycles", 64'(n), 64'(exp_busy));
        chk(result_valid === 1'b1, "rv_done", 64'(result_valid), 64'd1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk({busy, result_valid} === 2'b01, "hold_done", 64'({busy, result_valid}), 64'b01);
        end
        advanceE = 1'b1;
        @(posedge clk); #1;
        advanceE = 1'b0;
        startE   = 1'b0;
        last_hi  = e[63:32];
        last_lo  = e[31:0];
    endtask

    task automatic idle(input int n);
        startE = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk({busy, result_valid} === 2'b00, "idle", 64'({busy, result_valid}), 64'b00);
            @(posedge clk); #1;
        end
    endtask

    // Start a divide and kill it after 'at' cycles (still inside CALC).
    task automatic cancel_op(input logic [31:0] a, input logic [31:0] b, input int at);
        startE = 1'b1; opE = 2'b10; srcaE = a; srcbE = b; advanceE = 1'b0; cancelE = 1'b0;
        repeat (at) @(posedge clk);
        #1;
        cancelE = 1'b1;
        startE  = 1'b0;
        @(negedge clk);
        chk(busy === 1'b1, "busy_in_calc", 64'(busy), 64'd1);
        @(posedge clk); #1;
        cancelE = 1'b0;
        @(negedge clk);
        chk({busy, result_valid} === 2'b00, "after_cancel", 64'({busy, result_valid}), 64'b00);
        chk({hi, lo} === {last_hi, last_lo}, "hilo_after_cancel", {hi, lo}, {last_hi, last_lo});
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk({result_valid, hi, lo} === {1'b0, last_hi, last_lo}, "no_late_result", {hi, lo}, {last_hi, last_lo});
        @(posedge clk); #1;
    endtask

    initial begin
        resetn = 1'b0; startE = 1'b0; opE = 2'b00; srcaE = '0; srcbE = '0;
        advanceE = 1'b0; cancelE = 1'b0;
        #12;
        chk({busy, result_valid, hi, lo} === '0, "reset_state", {hi, lo}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;

        run_op(2'b11, 32'd100, 32'd7, 0);
        idle(1);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1);
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 0);
        run_op(2'b00, 32'hFFFF_FFFF, 32'd2, 0);
        run_op(2'b01, 32'hFFFF_FFFF, 32'd2, 0);
        run_op(2'b11, 32'd5, 32'd0, 0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd0, 0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0);
        run_op(2'b11, 32'd1000, 32'd3, 3);
        idle(2);
        cancel_op(32'd12345, 32'd77, 11);
        run_op(2'b11, 32'd100, 32'd7, 0);

        // Asynchronous reset mid-CALC.
        startE = 1'b1; opE = 2'b10; srcaE = 32'd999; srcbE = 32'd4;
        repeat (15) @(posedge clk);
        #3;
        resetn = 1'b0;
        startE = 1'b0;
        #1;
        chk({busy, result_valid, hi, lo} === '0, "async_reset", {hi, lo}, 64'd0);
        @(negedge clk);
        resetn  = 1'b1;
        last_hi = '0;
        last_lo = '0;
        @(posedge clk); #1;

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            op = 2'($urandom_range(0, 3));
            a  = rnd_opnd();
            b  = rnd_opnd();
            if ($urandom_range(0, 7) == 0)
                cancel_op(a, b, $urandom_range(1, 30));
            else
                run_op(op, a, b, $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
        end

        idle(3);
        chk(exp_q.size() == 0, "scoreboard_drain", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
